// File: rtl/acc_sched_pkg.sv
// Shared types and helpers for the round-robin accumulate scheduler.
package acc_sched_pkg;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps from N-1 to 0.
module rr_arbiter
  import acc_sched_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [IW-1:0] sel;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    sel     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sel = IW'((32'(ptr) + i) % N);
      if (!any && req[sel]) begin
        any      = 1'b1;
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/acc_scheduler.sv
// Round-robin scheduler sharing one accumulate datapath among N requesters.
// Define ACC_SAT_EN for a saturating adder; default build wraps modulo 2^W.
module acc_scheduler
  import acc_sched_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8,
  localparam int unsigned IW = idx_width(N)
) (
  input  logic            clock,
  input  logic            reset_L,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    valid,
  input  logic [N-1:0]    last,
  input  logic [N*W-1:0]  data,
  output logic [N-1:0]    grant,
  output logic            done,
  output logic [IW-1:0]   done_id,
  output logic [W-1:0]    result,
  output logic            ovf
);

  state_e        state_q;
  logic [IW-1:0] gidx_q;
  logic [IW-1:0] ptr_q;
  logic [W-1:0]  acc_q;
  logic          ovf_q;

  logic [N-1:0]  arb_gnt;
  logic [IW-1:0] arb_idx;
  logic          arb_any;
  logic [IW-1:0] ptr_next;

  logic          sel_req, sel_valid, sel_last;
  logic [W-1:0]  sel_data;
  logic [W:0]    sum_ext;
  logic          carry;
  logic [W-1:0]  acc_next;

  rr_arbiter #(.N(N)) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  assign ptr_next  = (arb_idx == IW'(N - 1)) ? '0 : arb_idx + 1'b1;
  assign sel_req   = req[gidx_q];
  assign sel_valid = valid[gidx_q];
  assign sel_last  = last[gidx_q];

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gidx_q == IW'(i)) sel_data = data[i*W +: W];
    end
  end

  assign sum_ext = {1'b0, acc_q} + {1'b0, sel_data};
  assign carry   = sum_ext[W];

`ifdef ACC_SAT_EN
  assign acc_next = carry ? '1 : sum_ext[W-1:0];
`else
  assign acc_next = sum_ext[W-1:0];
`endif

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= StIdle;
      gidx_q  <= '0;
      ptr_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      grant   <= '0;
      done    <= 1'b0;
      done_id <= '0;
      result  <= '0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (arb_any) begin
            grant   <= arb_gnt;
            gidx_q  <= arb_idx;
            ptr_q   <= ptr_next;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (sel_valid) begin
            acc_q <= acc_next;
            ovf_q <= ovf_q | carry;
          end
          // Completion beats a simultaneous req drop.
          if (sel_valid && sel_last) begin
            state_q <= StDone;
            done    <= 1'b1;
            result  <= acc_next;
            done_id <= gidx_q;
            ovf     <= ovf_q | carry;
          end else if (!sel_req) begin
            grant   <= '0;
            state_q <= StIdle;
          end
        end
        StDone: begin
          grant   <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_scheduler.sv
// Directed self-checking bench for acc_scheduler (N=4, W=8).
module tb_acc_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned IW = 2;

  logic            clock;
  logic            reset_L;
  logic [N-1:0]    req, valid, last;
  logic [N*W-1:0]  data;
  logic [N-1:0]    grant;
  logic            done;
  logic [IW-1:0]   done_id;
  logic [W-1:0]    result;
  logic            ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done_cyc = 0;

  acc_scheduler #(.N(N), .W(W)) dut (
    .clock   (clock),
    .reset_L (reset_L),
    .req     (req),
    .valid   (valid),
    .last    (last),
    .data    (data),
    .grant   (grant),
    .done    (done),
    .done_id (done_id),
    .result  (result),
    .ovf     (ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic lane(input int i, input logic v, input logic l, input logic [7:0] d);
    valid[i]         = v;
    last[i]          = l;
    data[i*W +: W]   = d;
  endtask

  task automatic clear_in();
    req = '0; valid = '0; last = '0; data = '0;
  endtask

`ifdef ACC_SAT_EN
  localparam logic [7:0] OvfSum = 8'd255;
`else
  localparam logic [7:0] OvfSum = 8'd44;
`endif

  initial begin
    reset_L = 1'b0;
    clear_in();
    #3;
    check("rst_grant", 32'(grant), 0);
    check("rst_done", 32'(done), 0);
    check("rst_result", 32'(result), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_done_id", 32'(done_id), 0);
    #1 reset_L = 1'b1;

    // Single 3-beat job on requester 2: 5+7+9
    req = 4'b0100;
    step();
    check("t1_grant", 32'(grant), 32'b0100);
    lane(2, 1'b1, 1'b0, 8'd5); step();
    check("t1_nodone", 32'(done), 0);
    lane(2, 1'b1, 1'b0, 8'd7); step();
    lane(2, 1'b1, 1'b1, 8'd9); step();
    check("t1_done", 32'(done), 1);
    check("t1_result", 32'(result), 21);
    check("t1_id", 32'(done_id), 2);
    check("t1_ovf", 32'(ovf), 0);
    check("t1_grant_done", 32'(grant), 32'b0100);
    clear_in(); step();
    check("t1_done_pulse", 32'(done), 0);
    check("t1_grant_idle", 32'(grant), 0);
    check("t1_result_hold", 32'(result), 21);

    // Fairness: fresh pointer, all requesting 1-beat jobs, lane i carries i+1
    #2 reset_L = 1'b0;
    #1 reset_L = 1'b1;
    req = 4'b1111; valid = 4'b1111; last = 4'b1111;
    data = {8'd4, 8'd3, 8'd2, 8'd1};
    for (int j = 0; j < 5; j++) begin
      step();
      check("rr_grant", 32'(grant), 32'(1 << (j % 4)));
      step();
      check("rr_done", 32'(done), 1);
      check("rr_id", 32'(done_id), 32'(j % 4));
      check("rr_result", 32'(result), 32'((j % 4) + 1));
      if (j > 0) check("rr_period", 32'(cyc - last_done_cyc), 3);
      last_done_cyc = cyc;
      step();
      check("rr_idle", 32'(grant), 0);
    end
    clear_in();

    // Overflow on requester 1: 200+100 (pointer at 1)
    req = 4'b0010; step();
    check("ov_grant", 32'(grant), 32'b0010);
    lane(1, 1'b1, 1'b0, 8'd200); step();
    lane(1, 1'b1, 1'b1, 8'd100); step();
    check("ov_done", 32'(done), 1);
    check("ov_result", 32'(result), 32'(OvfSum));
    check("ov_flag", 32'(ovf), 1);
    clear_in(); step();

    // Abort: requester 1 drops req after one beat; requester 2 is next
    req = 4'b0010; step();
    check("ab_grant", 32'(grant), 32'b0010);
    lane(1, 1'b1, 1'b0, 8'd10); step();
    clear_in(); req = 4'b0100; step();
    check("ab_grant_drop", 32'(grant), 0);
    check("ab_nodone", 32'(done), 0);
    check("ab_result_hold", 32'(result), 32'(OvfSum));
    step();
    check("ab_next_grant", 32'(grant), 32'b0100);
    lane(2, 1'b1, 1'b1, 8'd3); step();
    check("ab2_done", 32'(done), 1);
    check("ab2_result", 32'(result), 3);
    check("ab2_ovf", 32'(ovf), 0);
    clear_in(); step();

    // Stalls on requester 0 while requester 3 drives an unowned lane
    req = 4'b0001; step();
    check("st_grant", 32'(grant), 32'b0001);
    lane(0, 1'b1, 1'b0, 8'd11); step();
    lane(0, 1'b0, 1'b0, 8'd0);
    lane(3, 1'b1, 1'b1, 8'd99);
    for (int k = 0; k < 4; k++) begin
      step();
      check("st_nodone", 32'(done), 0);
      check("st_grant_hold", 32'(grant), 32'b0001);
    end
    lane(0, 1'b1, 1'b1, 8'd22); step();
    check("st_done", 32'(done), 1);
    check("st_result", 32'(result), 33);
    check("st_id", 32'(done_id), 0);
    clear_in(); step();

    // Async reset while BUSY
    req = 4'b0100; step();
    lane(2, 1'b1, 1'b0, 8'd50); step();
    check("ar_busy_grant", 32'(grant), 32'b0100);
    #2 reset_L = 1'b0;
    #1;
    check("ar_grant", 32'(grant), 0);
    check("ar_result", 32'(result), 0);
    check("ar_done_id", 32'(done_id), 0);
    check("ar_ovf", 32'(ovf), 0);
    #1 reset_L = 1'b1;
    clear_in(); req = 4'b1111; step();
    check("ar_restart", 32'(grant), 32'b0001);
    clear_in(); step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_scheduler.md
# acc_scheduler

Round-robin scheduler that shares one W-bit accumulate datapath (adder feeding an enable-controlled register) among N requesters. A requester wins a job, streams operands into the accumulator, marks the final beat, and receives the sum with a one-cycle done pulse tagged with its ID. The block sits between multiple job sources and the shared accumulator and is the only path to that datapath.

## Interface
- N, default 4: number of requesters (2..8)
- W, default 8: operand / accumulator width
- clock  input  1  system clock, rising edge
- reset_L  input  1  asynchronous, active-low reset
- req  input  N  req[i] = requester i wants or holds the accumulator
- valid  input  N  valid[i] = requester i presents an operand this cycle
- last  input  N  last[i] = operand from requester i is its final beat
- data  input  N*W  flattened operands; requester i on data[i*W +: W]
- grant  output  N  one-hot grant, all zero when idle
- done  output  1  one-cycle pulse, result valid
- done_id  output  $clog2(N)  requester index for result
- result  output  W  accumulated sum
- ovf  output  1  overflow occurred during the reported job

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: grant=0. If any req bit set, pick winner with the round-robin arbiter, clear accumulator and ovf, register grant, go BUSY. Else stay.
- BUSY: only the granted requester's valid/last/data are observed; all others are ignored.
  - valid[g]: acc <= acc + data[g]; unsigned carry out sets sticky ovf.
  - valid[g] && last[g]: add that beat, go DONE.
  - req[g] low without valid&&last: abort; grant drops, no done, go IDLE, accumulator contents discarded.
  - req[g] low in the same cycle as valid[g]&&last[g]: completion wins and the job goes DONE.
- DONE: done=1, result=acc, done_id=g, ovf=sticky flag. grant stays asserted this cycle. Next state IDLE.
- Round-robin: a pointer holds the index after the last granted requester. The search starts at the pointer and wraps from N-1 to 0. The pointer updates on every grant, including jobs that later abort. At reset the pointer is 0.
- Arithmetic: unsigned, modulo 2^W (without ACC_SAT_EN).

## Timing
- Reset (async, reset_L=0): state IDLE, grant=0, done=0, done_id=0, result=0, ovf=0, accumulator=0, pointer=0. Reset mid-job drops the job silently.
- Grant latency: req sampled in IDLE at edge k; grant is visible after edge k. The first operand is accepted at edge k+1.
- Single-beat job: valid&&last at the first BUSY edge; done is high in the following cycle.
- Done latency: one cycle after the edge that accepts the last beat.
- Back-to-back: after DONE there is always one IDLE cycle before the next grant. Minimum job period is 3 cycles for 1 beat.
- result, done_id and ovf are held after done until the next done. done itself is a pulse.
- Beats with valid low in BUSY are stalls with no timeout.

## Configuration
- ACC_SAT_EN defined:
  - The adder saturates; if acc + data exceeds 2^W-1, the accumulator becomes 2^W-1 and stays clamped for the rest of the job.
  - ovf is still set on any clamp.
- ACC_SAT_EN undefined:
  - The sum wraps modulo 2^W.
  - ovf is sticky on any carry out.

## Structure
- Package acc_sched_pkg holds the state enum (IDLE, BUSY, DONE) and a function computing the index width from N.
- Sub-module rr_arbiter #(N):
  - Inputs: req, pointer.
  - Outputs: one-hot gnt, gnt_idx, any.
  - Purely combinational; the pointer register lives in acc_scheduler.
- The accumulator register and adder stay in the top-level module, with enable = BUSY && valid[g].

## Test plan
- Reset and single job: reset, req[2]=1, 3 beats 5,7,9 with last on 9. Required: grant=0100, done pulse with result=21, done_id=2, ovf=0.
- Round-robin fairness: req=1111 held, 1-beat jobs.
  - Grants in order 0,1,2,3,0.
  - Each done is separated by exactly 3 cycles.
- Overflow (W=8): beats 200, 100.
  - Without ACC_SAT_EN: result=44, ovf=1.
  - With ACC_SAT_EN: result=255, ovf=1.
- Abort: req[1] drops after one beat of value 10. Required:
  - grant returns to 0 and no done pulse.
  - Next grant goes to requester 2 if it is requesting.
- Stalls and ignored lanes: the granted requester idles valid for 4 cycles while requester 3 drives valid/last/data=99. Required: requester 3 lanes are ignored and the final sum includes only the granted requester's beats.
- Async reset mid-job: reset_L low during BUSY.
  - Outputs clear immediately with no clock edge.
  - After release, arbitration restarts at requester 0.
